// File: rtl/bp_fe_queue_pkg.sv
// Shared types and helpers for the FE-to-BE queue with speculative read checkpointing.
package bp_fe_queue_pkg;

    // Source of the read-pointer update, highest priority first: clr > roll > yumi.
    typedef enum logic [1:0] {
        RdNone,
        RdYumi,
        RdRoll,
        RdClr
    } rd_src_e;

    // Pointer width: index bits plus one wrap bit, so 0..els entries are all representable.
    function automatic int ptr_width(input int els);
        return $clog2(els) + 1;
    endfunction

endpackage

// File: rtl/bp_fe_queue_rb_ptr.sv
// Wrapping queue pointer: synchronous reset to zero, load has priority over increment.
module bp_fe_queue_rb_ptr #(
    parameter int unsigned width_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               inc,
    input  logic               load_v,
    input  logic [width_p-1:0] load_val,
    output logic [width_p-1:0] ptr
);

    localparam logic [width_p-1:0] one = width_p'(1);

    logic [width_p-1:0] ptr_next;

    always_comb begin
        ptr_next = ptr;
        if (load_v) begin
            ptr_next = load_val;
        end else if (inc) begin
            ptr_next = ptr + one;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/bp_fe_queue_rb.sv
// FE-to-BE queue: speculative read (yumi), commit (deq), rewind (roll) and flush (clr).
// Optional same-cycle enqueue-to-read bypass when BP_FE_QUEUE_BYPASS_EN is defined.
module bp_fe_queue_rb
    import bp_fe_queue_pkg::*;
#(
    parameter int unsigned width_p = 128,
    parameter int unsigned els_p   = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] fe_queue_i,
    input  logic               fe_queue_v_i,
    output logic               fe_queue_ready_o,
    output logic [width_p-1:0] fe_queue_o,
    output logic               fe_queue_v_o,
    input  logic               fe_queue_yumi_i,
    input  logic               fe_queue_deq_i,
    input  logic               fe_queue_roll_i,
    input  logic               fe_queue_clr_i
);

    localparam int ptr_w = ptr_width(int'(els_p));
    localparam int idx_w = ptr_w - 1;

    logic [ptr_w-1:0]   wptr;
    logic [ptr_w-1:0]   rptr;
    logic [ptr_w-1:0]   cptr;
    logic [ptr_w-1:0]   cptr_next;
    logic [ptr_w-1:0]   rptr_load;
    logic [width_p-1:0] mem [els_p];
    logic               full;
    logic               empty;
    logic               enq_fire;
    logic               cptr_inc;
    logic               rptr_inc;
    logic               rptr_load_v;
    rd_src_e            rd_src;

    // Occupancy is measured from the commit pointer: consumed entries still hold their slots.
    assign full             = (wptr[idx_w-1:0] == cptr[idx_w-1:0]) && (wptr[idx_w] != cptr[idx_w]);
    assign empty            = (rptr == wptr);
    assign fe_queue_ready_o = ~full;
    assign enq_fire         = fe_queue_v_i & fe_queue_ready_o & ~fe_queue_clr_i;
    assign cptr_inc         = fe_queue_deq_i & ~fe_queue_clr_i;
    assign cptr_next        = cptr + {{idx_w{1'b0}}, cptr_inc};

    always_comb begin
        rd_src = RdNone;
        if (fe_queue_clr_i) begin
            rd_src = RdClr;
        end else if (fe_queue_roll_i) begin
            rd_src = RdRoll;
        end else if (fe_queue_yumi_i) begin
            rd_src = RdYumi;
        end
    end

    // Roll rewinds to the commit pointer including a same-cycle deq.
    always_comb begin
        rptr_inc    = 1'b0;
        rptr_load_v = 1'b0;
        rptr_load   = cptr_next;
        unique case (rd_src)
            RdClr: begin
                rptr_load_v = 1'b1;
                rptr_load   = wptr;
            end
            RdRoll: rptr_load_v = 1'b1;
            RdYumi: rptr_inc = 1'b1;
            default: ;
        endcase
    end

    bp_fe_queue_rb_ptr #(.width_p(ptr_w)) u_wptr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .inc     (enq_fire),
        .load_v  (1'b0),
        .load_val('0),
        .ptr     (wptr)
    );

    bp_fe_queue_rb_ptr #(.width_p(ptr_w)) u_rptr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .inc     (rptr_inc),
        .load_v  (rptr_load_v),
        .load_val(rptr_load),
        .ptr     (rptr)
    );

    bp_fe_queue_rb_ptr #(.width_p(ptr_w)) u_cptr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .inc     (cptr_inc),
        .load_v  (fe_queue_clr_i),
        .load_val(wptr),
        .ptr     (cptr)
    );

    always_ff @(posedge clk_i) begin
        if (enq_fire) begin
            mem[wptr[idx_w-1:0]] <= fe_queue_i;
        end
    end

`ifdef BP_FE_QUEUE_BYPASS_EN
    // Entry is still written to storage so a later roll can replay it.
    logic bypass;
    assign bypass       = empty & enq_fire;
    assign fe_queue_v_o = ~empty | bypass;
    assign fe_queue_o   = bypass ? fe_queue_i : mem[rptr[idx_w-1:0]];
`else
    assign fe_queue_v_o = ~empty;
    assign fe_queue_o   = mem[rptr[idx_w-1:0]];
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i && !fe_queue_clr_i) begin
            if (!fe_queue_roll_i) begin
                assert (!fe_queue_yumi_i || fe_queue_v_o)
                    else $error("bp_fe_queue_rb: yumi while fe_queue_v_o is low");
            end
            assert (!fe_queue_deq_i || (cptr != rptr))
                else $error("bp_fe_queue_rb: deq with no consumed entry");
        end
    end
`endif

endmodule

// File: tb/tb_bp_fe_queue_rb.sv
// Self-checking bench for bp_fe_queue_rb: queue-based reference model plus directed pins.
module tb_bp_fe_queue_rb;

    localparam int W = 128;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] fe_queue_i;
    logic         fe_queue_v_i;
    logic         ready;
    logic [W-1:0] fe_queue_o;
    logic         v_o;
    logic         yumi;
    logic         deq;
    logic         roll;
    logic         clr;

    bp_fe_queue_rb #(.width_p(W), .els_p(N)) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .fe_queue_i      (fe_queue_i),
        .fe_queue_v_i    (fe_queue_v_i),
        .fe_queue_ready_o(ready),
        .fe_queue_o      (fe_queue_o),
        .fe_queue_v_o    (v_o),
        .fe_queue_yumi_i (yumi),
        .fe_queue_deq_i  (deq),
        .fe_queue_roll_i (roll),
        .fe_queue_clr_i  (clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: mq holds every uncommitted entry, oldest first; rd counts consumed-but-uncommitted.
    logic [W-1:0] mq[$];
    int           rd = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit m_ready();
        return mq.size() < N;
    endfunction

    function automatic bit m_fire();
        return fe_queue_v_i && m_ready() && !clr;
    endfunction

    function automatic bit m_valid();
`ifdef BP_FE_QUEUE_BYPASS_EN
        return (rd < mq.size()) || (rd == mq.size() && m_fire());
`else
        return rd < mq.size();
`endif
    endfunction

    function automatic logic [W-1:0] m_data();
        return (rd < mq.size()) ? mq[rd] : fe_queue_i;
    endfunction

    always @(posedge clk) begin
        bit fire;
        fire = m_fire();
        if (reset || clr) begin
            mq.delete();
            rd = 0;
        end else begin
            if (deq) begin
                void'(mq.pop_front());
                rd--;
            end
            if (roll) rd = 0;
            else if (yumi) rd++;
            if (fire) mq.push_back(fe_queue_i);
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("model_ready", W'(ready), W'(m_ready()));
            check("model_valid", W'(v_o), W'(m_valid()));
            if (m_valid()) check("model_data", fe_queue_o, m_data());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [W-1:0] d, input bit y, input bit dq,
                         input bit rl, input bit c);
        fe_queue_v_i = v;
        fe_queue_i   = d;
        yumi         = y;
        deq          = dq;
        roll         = rl;
        clr          = c;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < 4 * N && mq.size() > 0; k++) begin
            drive(1'b0, '0, rd < mq.size(), rd > 0, 1'b0, 1'b0);
            tick();
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("reset_ready", W'(ready), W'(1));
        check("reset_valid", W'(v_o), W'(0));

        // Fill and drain
        for (int i = 0; i < N; i++) begin
            drive(1'b1, W'(i + 1), 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        idle();
        #1;
        check("fill_ready", W'(ready), W'(0));
        check("fill_head", fe_queue_o, W'(1));
        for (int i = 0; i < N; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
            #1;
            check("fill_order", fe_queue_o, W'(i + 1));
            tick();
        end
        idle();
        #1;
        check("drained_valid", W'(v_o), W'(0));
        check("drained_ready", W'(ready), W'(0));
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        check("deq_same_cycle_ready", W'(ready), W'(0));
        tick();
        idle();
        #1;
        check("deq_next_ready", W'(ready), W'(1));
        drain();

        // Rollback replay
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, W'(32'hA + i), 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        #1;
        check("roll_valid", W'(v_o), W'(1));
        check("roll_replay_b", fe_queue_o, W'(32'hB));
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        #1;
        check("roll_replay_c", fe_queue_o, W'(32'hC));
        tick();
        drain();

        // Roll and deq in the same cycle
        drive(1'b1, W'(32'hA), 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, W'(32'hB), 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        idle();
        #1;
        check("rolldeq_valid", W'(v_o), W'(1));
        check("rolldeq_data", fe_queue_o, W'(32'hB));
        drain();

        // Clr with a concurrent enqueue
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, W'(i + 1), 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, W'(32'hD), 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        #1;
        check("clr_valid", W'(v_o), W'(0));
        check("clr_ready", W'(ready), W'(1));
        drive(1'b1, W'(32'hE), 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        #1;
        check("clr_no_d", fe_queue_o, W'(32'hE));
        drain();

        // Steady depth across pointer wrap
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, W'(32'h100 + i), 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, W'(32'h103 + i), 1'b1, i > 0, 1'b0, 1'b0);
            #1;
            check("wrap_order", fe_queue_o, W'(32'h100 + i));
            check("wrap_ready", W'(ready), W'(1));
            tick();
        end
        drain();

        // Enqueue on empty queue, with or without bypass
`ifdef BP_FE_QUEUE_BYPASS_EN
        drive(1'b1, W'(32'h5), 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("bypass_valid", W'(v_o), W'(1));
        check("bypass_data", fe_queue_o, W'(32'h5));
        tick();
        idle();
        #1;
        check("bypass_consumed", W'(v_o), W'(0));
`else
        drive(1'b1, W'(32'h5), 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("nobypass_valid", W'(v_o), W'(0));
        tick();
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("nobypass_next", fe_queue_o, W'(32'h5));
        tick();
`endif
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        #1;
        check("bypass_roll_valid", W'(v_o), W'(1));
        check("bypass_roll_data", fe_queue_o, W'(32'h5));
        drain();

        // Randomized traffic, including mid-run resets
        for (int c = 0; c < 3000; c++) begin
            reset        = ($urandom_range(0, 999) < 5);
            clr          = !reset && ($urandom_range(0, 99) < 3);
            roll         = ($urandom_range(0, 99) < 5);
            yumi         = (rd < mq.size()) && ($urandom_range(0, 1) == 1);
            deq          = (rd > 0) && ($urandom_range(0, 1) == 1);
            fe_queue_v_i = ($urandom_range(0, 99) < 60);
            fe_queue_i   = {$urandom(), $urandom(), $urandom(), $urandom()};
            tick();
        end
        reset = 1'b0;
        idle();
        drain();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
